// File: rtl/wrap_ring_allocator_pkg.sv
// Shared ring-allocator definitions: default geometry and derived widths.
package wrap_ring_allocator_pkg;

    localparam int RING_DEPTH = 40;
    localparam int RING_MAX_N = 4;
    localparam int RING_PTR_W = $clog2(RING_DEPTH);
    localparam int RING_CNT_W = $clog2(RING_DEPTH + 1);
    localparam int RING_NUM_W = $clog2(RING_MAX_N + 1);

endpackage

// File: rtl/add_wraparound_modn.sv
// Combinational (a + b) mod DEPTH for operands already below DEPTH.
module add_wraparound_modn
    import wrap_ring_allocator_pkg::*;
#(
    parameter int DEPTH = RING_DEPTH,
    parameter int PTR_W = RING_PTR_W
) (
    input  logic [PTR_W-1:0] a,
    input  logic [PTR_W-1:0] b,
    output logic [PTR_W-1:0] sum
);

    localparam logic [PTR_W:0] DEPTH_EXT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0] raw_sum;
    logic [PTR_W:0] wrapped;
    logic           borrow;

    // Full-width sum, then one conditional subtraction of DEPTH.
    always_comb begin
        raw_sum           = {1'b0, a} + {1'b0, b};
        {borrow, wrapped} = {1'b0, raw_sum} - {1'b0, DEPTH_EXT};
        sum               = borrow ? raw_sum[PTR_W-1:0] : wrapped[PTR_W-1:0];
    end

endmodule

// File: rtl/wrap_ring_allocator.sv
// Ring-buffer slot allocator for non-power-of-two depths, with a modular index query port.
module wrap_ring_allocator
    import wrap_ring_allocator_pkg::*;
#(
    parameter int DEPTH = RING_DEPTH,
    parameter int PTR_W = RING_PTR_W,
    parameter int MAX_N = RING_MAX_N,
    parameter int CNT_W = RING_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       alloc_valid,
    input  logic [$clog2(MAX_N+1)-1:0] alloc_num,
    output logic                       alloc_ack,
    output logic [PTR_W-1:0]           alloc_base,
    input  logic                       free_valid,
    input  logic [$clog2(MAX_N+1)-1:0] free_num,
    input  logic                       idx_valid,
    input  logic [PTR_W-1:0]           idx_base,
    input  logic [PTR_W-1:0]           idx_offset,
    output logic                       idx_out_valid,
    output logic [PTR_W-1:0]           idx_out,
    output logic [PTR_W-1:0]           head,
    output logic [PTR_W-1:0]           tail,
    output logic [CNT_W-1:0]           occupancy,
    output logic                       full,
    output logic                       empty,
    output logic                       underflow_err
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] occ_q;
    logic             underflow_q;

    logic [CNT_W-1:0] free_count;
    logic [CNT_W-1:0] alloc_cnt;
    logic [CNT_W-1:0] free_cnt;
    logic             free_ok;
    logic             free_bad;
    logic [CNT_W-1:0] occ_next;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] idx_sum;

    assign alloc_cnt  = CNT_W'(alloc_num);
    assign free_cnt   = CNT_W'(free_num);
    assign free_count = DEPTH_CNT - occ_q;

    // Grant/release decisions use registered occupancy only, so a same-cycle
    // free cannot make room for a same-cycle alloc.
    always_comb begin
        alloc_ack = alloc_valid && (alloc_num != '0) && (alloc_cnt <= free_count) && !flush;
        free_ok   = free_valid && (free_num != '0) && (free_cnt <= occ_q) && !flush;
        free_bad  = free_valid && (free_cnt > occ_q) && !flush;
    end

    // Occupancy update; a granted alloc never exceeds free_count so no overflow.
    always_comb begin
        occ_next = occ_q;
        if (alloc_ack) begin
            occ_next = occ_next + alloc_cnt;
        end
        if (free_ok) begin
            occ_next = occ_next - free_cnt;
        end
    end

    add_wraparound_modn #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_add (
        .a   (tail_q),
        .b   (PTR_W'(alloc_num)),
        .sum (tail_next)
    );

    add_wraparound_modn #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_add (
        .a   (head_q),
        .b   (PTR_W'(free_num)),
        .sum (head_next)
    );

    add_wraparound_modn #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_idx_add (
        .a   (idx_base),
        .b   (idx_offset),
        .sum (idx_sum)
    );

    // Ring state register; flush overrides any alloc/free in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (alloc_ack) begin
                tail_q <= tail_next;
            end
            if (free_ok) begin
                head_q <= head_next;
            end
            occ_q       <= occ_next;
            underflow_q <= underflow_q | free_bad;
        end
    end

    // Query pipeline stage, independent of ring state and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_out_valid <= 1'b0;
            idx_out       <= '0;
        end else begin
            idx_out_valid <= idx_valid;
            idx_out       <= idx_sum;
        end
    end

    assign alloc_base    = tail_q;
    assign head          = head_q;
    assign tail          = tail_q;
    assign occupancy     = occ_q;
    assign full          = (occ_q == DEPTH_CNT);
    assign empty         = (occ_q == '0);
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_wrap_ring_allocator.sv
// Self-checking bench for wrap_ring_allocator (DEPTH=40, MAX_N=4).
module tb_wrap_ring_allocator;

    localparam int DEPTH = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       alloc_valid;
    logic [2:0] alloc_num;
    logic       alloc_ack;
    logic [5:0] alloc_base;
    logic       free_valid;
    logic [2:0] free_num;
    logic       idx_valid;
    logic [5:0] idx_base;
    logic [5:0] idx_offset;
    logic       idx_out_valid;
    logic [5:0] idx_out;
    logic [5:0] head;
    logic [5:0] tail;
    logic [5:0] occupancy;
    logic       full;
    logic       empty;
    logic       underflow_err;

    wrap_ring_allocator #(.DEPTH(40), .PTR_W(6), .MAX_N(4), .CNT_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .alloc_valid   (alloc_valid),
        .alloc_num     (alloc_num),
        .alloc_ack     (alloc_ack),
        .alloc_base    (alloc_base),
        .free_valid    (free_valid),
        .free_num      (free_num),
        .idx_valid     (idx_valid),
        .idx_base      (idx_base),
        .idx_offset    (idx_offset),
        .idx_out_valid (idx_out_valid),
        .idx_out       (idx_out),
        .head          (head),
        .tail          (tail),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: plain integer ring bookkeeping.
    int m_head, m_tail, m_occ, m_uf, m_qv, m_q;
    int last_ack;

    typedef struct {
        int base;
        int off;
        int exp;
    } query_vec_t;

    query_vec_t qtab[6];

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_occ = 0; m_uf = 0; m_qv = 0; m_q = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ":head"}, int'(head), m_head);
        check({tag, ":tail"}, int'(tail), m_tail);
        check({tag, ":occupancy"}, int'(occupancy), m_occ);
        check({tag, ":full"}, int'(full), int'(m_occ == DEPTH));
        check({tag, ":empty"}, int'(empty), int'(m_occ == 0));
        check({tag, ":underflow_err"}, int'(underflow_err), m_uf);
        check({tag, ":idx_out_valid"}, int'(idx_out_valid), m_qv);
        if (m_qv != 0) check({tag, ":idx_out"}, int'(idx_out), m_q);
    endtask

    // One clock cycle: drive, check combinational grant, clock, check state.
    task automatic step(input string tag, input int fl, input int av, input int an,
                        input int fv, input int fn, input int iv, input int ib, input int io);
        int exp_ack, fok, fbad;
        flush       = fl[0];
        alloc_valid = av[0];
        alloc_num   = 3'(an);
        free_valid  = fv[0];
        free_num    = 3'(fn);
        idx_valid   = iv[0];
        idx_base    = 6'(ib);
        idx_offset  = 6'(io);
        #1;
        exp_ack = int'(av != 0 && an != 0 && an <= DEPTH - m_occ && fl == 0);
        fok     = int'(fv != 0 && fn != 0 && fn <= m_occ && fl == 0);
        fbad    = int'(fv != 0 && fn > m_occ && fl == 0);
        check({tag, ":alloc_ack"}, int'(alloc_ack), exp_ack);
        check({tag, ":alloc_base"}, int'(alloc_base), m_tail);
        last_ack = int'(alloc_ack);
        @(posedge clk);
        #1;
        if (fl != 0) begin
            m_head = 0; m_tail = 0; m_occ = 0; m_uf = 0;
        end else begin
            if (exp_ack != 0) begin
                m_tail = (m_tail + an) % DEPTH;
                m_occ  = m_occ + an;
            end
            if (fok != 0) begin
                m_head = (m_head + fn) % DEPTH;
                m_occ  = m_occ - fn;
            end
            if (fbad != 0) m_uf = 1;
        end
        m_qv = iv;
        m_q  = (ib + io) % DEPTH;
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        qtab[0] = '{base: 39, off: 39, exp: 38};
        qtab[1] = '{base: 20, off: 19, exp: 39};
        qtab[2] = '{base: 20, off: 20, exp: 0};
        qtab[3] = '{base: 0,  off: 0,  exp: 0};
        qtab[4] = '{base: 1,  off: 38, exp: 39};
        qtab[5] = '{base: 39, off: 1,  exp: 0};

        rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_num = '0;
        free_valid = 1'b0; free_num = '0; idx_valid = 1'b0; idx_base = '0; idx_offset = '0;
        last_ack = 0;
        model_reset();
        #2;
        check_state("reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill the ring with ten allocs of 4.
        for (int i = 0; i < 10; i++) begin
            check("fill:base_const", int'(alloc_base), i * 4);
            step("fill", 0, 1, 4, 0, 0, 0, 0, 0);
            check("fill:ack_const", last_ack, 1);
        end
        check("fill:full_const", int'(full), 1);
        check("fill:tail_const", int'(tail), 0);
        check("fill:occ_const", int'(occupancy), 40);

        // Simultaneous alloc/free when full: alloc judged pre-free.
        step("full_pair", 0, 1, 4, 1, 4, 0, 0, 0);
        check("full_pair:ack_const", last_ack, 0);
        check("full_pair:occ_const", int'(occupancy), 36);
        step("pair36", 0, 1, 4, 1, 4, 0, 0, 0);
        check("pair36:ack_const", last_ack, 1);
        check("pair36:occ_const", int'(occupancy), 36);
        check("pair36:tail_const", int'(tail), 4);
        check("pair36:head_const", int'(head), 8);

        // Occupancy 38: alloc 3 refused, alloc 2 granted.
        step("to38", 0, 1, 2, 0, 0, 0, 0, 0);
        step("alloc3", 0, 1, 3, 0, 0, 0, 0, 0);
        check("alloc3:ack_const", last_ack, 0);
        check("alloc3:occ_const", int'(occupancy), 38);
        step("alloc2", 0, 1, 2, 0, 0, 0, 0, 0);
        check("alloc2:ack_const", last_ack, 1);

        // Head wrap and underflow.
        step("flush", 0 + 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step("a38", 0, 1, 4, 0, 0, 0, 0, 0);
        step("a38", 0, 1, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step("f38", 0, 0, 0, 1, 4, 0, 0, 0);
        step("f38", 0, 0, 0, 1, 2, 0, 0, 0);
        step("a5", 0, 1, 4, 0, 0, 0, 0, 0);
        step("a5", 0, 1, 1, 0, 0, 0, 0, 0);
        check("wrap:head_const", int'(head), 38);
        check("wrap:occ_const", int'(occupancy), 5);
        step("free4", 0, 0, 0, 1, 4, 0, 0, 0);
        check("free4:head_const", int'(head), 2);
        check("free4:occ_const", int'(occupancy), 1);
        step("free2", 0, 0, 0, 1, 2, 0, 0, 0);
        check("free2:uf_const", int'(underflow_err), 1);
        check("free2:head_const", int'(head), 2);
        idle("uf_hold");
        check("uf_hold:uf_const", int'(underflow_err), 1);

        // Flush during alloc.
        step("pre_flush", 0, 1, 3, 0, 0, 0, 0, 0);
        step("flush_alloc", 1, 1, 4, 0, 0, 0, 0, 0);
        check("flush_alloc:ack_const", last_ack, 0);
        check("flush_alloc:head_const", int'(head), 0);
        check("flush_alloc:tail_const", int'(tail), 0);
        check("flush_alloc:empty_const", int'(empty), 1);
        check("flush_alloc:uf_const", int'(underflow_err), 0);

        // Query table, each with a one-cycle latency.
        foreach (qtab[i]) begin
            step("query", 0, 0, 0, 0, 0, 1, qtab[i].base, qtab[i].off);
            check("query:idx_out_vec", int'(idx_out), qtab[i].exp);
            check("query:valid_vec", int'(idx_out_valid), 1);
        end
        step("query_flush", 1, 0, 0, 0, 0, 1, 20, 19);
        check("query_flush:idx_out_vec", int'(idx_out), 39);
        idle("query_off");

        // Randomized traffic against the model, with a mid-stream async reset.
        for (int n = 0; n < 600; n++) begin
            int fl, av, an, fv, fn;
            fl = int'($urandom_range(0, 49) == 0);
            av = int'($urandom_range(0, 3) != 0);
            an = int'($urandom_range(0, 4));
            fv = int'($urandom_range(0, 2) == 0);
            fn = (($urandom_range(0, 9) == 0) ? m_occ + 1 : int'($urandom_range(0, 4)));
            if (fn > 4) fn = 4;
            step("rand", fl, av, an, fv, fn, int'($urandom_range(0, 1)),
                 int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
            if (n == 300) begin
                idx_valid = 1'b1;
                #1;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_state("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                m_qv = 0;
                step("post_rst", 0, 1, 4, 1, 1, 0, 0, 0);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wrap_ring_allocator.md
WRAP_RING_ALLOCATOR -- requirements
Module: wrap_ring_allocator

Interface
REQ-001 SHALL have parameter DEPTH, default 40: ring size, any value 2..256, not restricted to a power of two.
REQ-002 SHALL have parameter PTR_W, default 6: pointer width; PTR_W SHALL equal ceil(log2(DEPTH)).
REQ-003 SHALL have parameter MAX_N, default 4: maximum entries allocated or freed per cycle; MAX_N <= DEPTH.
REQ-004 SHALL have parameter CNT_W, default 6: occupancy width; CNT_W SHALL equal ceil(log2(DEPTH+1)).
REQ-005 SHALL have a single clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 flush  input  1  synchronous clear of ring state.
REQ-009 alloc_valid  input  1  allocation request.
REQ-010 alloc_num  input  clog2(MAX_N+1)  entries requested, 1..MAX_N.
REQ-011 alloc_ack  output  1  request granted this cycle (combinational).
REQ-012 alloc_base  output  PTR_W  first granted index, equal to the current tail.
REQ-013 free_valid  input  1  release request.
REQ-014 free_num  input  clog2(MAX_N+1)  entries released from the head, 1..MAX_N.
REQ-015 idx_valid, idx_base[PTR_W], idx_offset[PTR_W]  inputs  modular index query.
REQ-016 idx_out_valid  output  1;  idx_out  output  PTR_W  registered query result.
REQ-017 head, tail  outputs  PTR_W;  occupancy  output  CNT_W;  full, empty  outputs  1.
REQ-018 underflow_err  output  1  sticky illegal-free flag.

Function
REQ-019 free_count SHALL be DEPTH - occupancy, computed from registered state only.
REQ-020 alloc_ack SHALL be asserted iff alloc_valid && alloc_num != 0 && alloc_num <= free_count && !flush.
REQ-021 On alloc_ack, tail SHALL become (tail + alloc_num) mod DEPTH at the next edge.
REQ-022 A free SHALL be legal iff free_valid && free_num != 0 && free_num <= occupancy && !flush.
REQ-023 On a legal free, head SHALL become (head + free_num) mod DEPTH at the next edge.
REQ-024 A free with free_num > occupancy SHALL leave state unchanged and set underflow_err, which holds until reset or flush.
REQ-025 For simultaneous alloc and free, alloc SHALL be judged against the pre-free free_count; both SHALL then apply, and occupancy_next = occupancy + granted - freed.
REQ-026 All modular sums SHALL be formed as a PTR_W+1-bit sum minus DEPTH, selected when the subtraction does not borrow; operands are always < DEPTH, so a single subtraction suffices.
REQ-027 full SHALL equal (occupancy == DEPTH); empty SHALL equal (occupancy == 0). When full, head == tail.
REQ-028 The query port SHALL have 1-cycle latency: idx_out = (idx_base + idx_offset) mod DEPTH, and idx_out_valid = idx_valid delayed by one cycle.
REQ-029 The query port SHALL be independent of ring state and flush. Inputs >= DEPTH are illegal, and the result for them is don't-care.
REQ-030 flush SHALL take priority over alloc and free: the next state is head = tail = 0, occupancy = 0, underflow_err = 0.

Reset
REQ-031 While rst_n = 0: head, tail, occupancy, idx_out, idx_out_valid and underflow_err SHALL be 0; empty SHALL be 1 and full SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight queries and requests; the first edge after release SHALL behave as on an empty ring.

Structure
REQ-033 DEPTH, MAX_N and the derived widths SHALL be defined in the shared global definitions include, and the wavefront default of 40 SHALL be taken from there.
REQ-034 A combinational sub-module add_wraparound_modn (parameters DEPTH and PTR_W) SHALL be instantiated three times: tail, head and query.
REQ-035 No other sub-modules SHALL be used, and total RTL SHALL be no more than 400 lines.

Verification (DEPTH=40, MAX_N=4)
REQ-036 Reset, then alloc 4 ten times -> alloc_ack each cycle, alloc_base 0,4,...,36; then full=1, tail=0, occupancy=40.
REQ-037 At occupancy 38, alloc 3 -> alloc_ack=0 and state unchanged; alloc 2 -> alloc_ack=1.
REQ-038 With head=38 and occupancy 5, free 4 -> head=2 and occupancy=1; then free 2 -> underflow_err=1 and head stays 2.
REQ-039 At occupancy 40, alloc 4 with free 4 in the same cycle -> alloc_ack=0, occupancy=36; at occupancy 36 the same pair -> ack=1, occupancy=36, tail and head both advance by 4 mod 40.
REQ-040 Query (39,39) -> idx_out=38; (20,19) -> 39; (20,20) -> 0; each result one cycle later with idx_out_valid=1.
REQ-041 Flush asserted during alloc -> ack=0, and the next cycle shows head=tail=0, empty=1; rst_n pulsed mid-stream -> outputs 0 immediately, without waiting for a clock edge.
